// File: rtl/spir_master.sv
// spir_master: SPI mode-0 initiator issuing one 48-bit register read/write frame per request to spir.
// Ports: clk/reset (sync, active-high); req_valid/req_ready/req_wr/req_addr/req_wdata request side;
// rsp_valid/rsp_rdata one-cycle response; spi_clk/spi_ncs/spi_do drive the slave, spi_di is its data out.
// Params: CLK_DIV = SPI half-period in clk cycles, CS_GAP = clk cycles spent in the chip-select gap.
// Build option: define SPIR_MASTER_SYNC_EN to double-flop spi_di and sample at the end of each high phase.
module spir_master #(
  parameter int CLK_DIV = 4,
  parameter int CS_GAP  = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_wr,
  input  logic [11:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        rsp_valid,
  output logic [31:0] rsp_rdata,
  output logic        spi_clk,
  output logic        spi_ncs,
  output logic        spi_do,
  input  logic        spi_di
);
  localparam logic [2:0] IDLE  = 3'd0;
  localparam logic [2:0] SETUP = 3'd1;
  localparam logic [2:0] SHIFT = 3'd2;
  localparam logic [2:0] HOLD  = 3'd3;
  localparam logic [2:0] GAP   = 3'd4;
  localparam logic [15:0] HM1 = 16'(CLK_DIV - 1);
  localparam logic [15:0] GM1 = 16'(CS_GAP - 1);
  logic [2:0]  state;
  logic [15:0] cnt;
  logic        ph;
  logic [5:0]  bits;
  logic [46:0] sh;
  logic [31:0] rsh;
  logic        wr;
  logic        di;
  logic        h_end;
  logic        smp;
  logic        shift_done;
  logic        last_hold;
`ifdef SPIR_MASTER_SYNC_EN
  logic di_s1, di_s2;
  always_ff @(posedge clk) begin
    if (reset) begin
      di_s1 <= 1'b0;
      di_s2 <= 1'b0;
    end else begin
      di_s1 <= spi_di;
      di_s2 <= di_s1;
    end
  end
  if (CLK_DIV < 3) begin : g_div_chk
    $error("spir_master: CLK_DIV must be >= 3 with SPIR_MASTER_SYNC_EN");
  end
  // synchroniser delay is absorbed by sampling at the very end of the high phase
  always_comb begin
    di  = di_s2;
    smp = state == SHIFT && ph && h_end;
  end
`else
  // sample on the edge that drives spi_clk high
  always_comb begin
    di  = spi_di;
    smp = state == SHIFT && !ph && h_end;
  end
`endif
  always_comb begin
    h_end      = cnt == HM1;
    shift_done = state == SHIFT && ph && h_end && bits == 6'd47;
    // rsp_valid is registered, so it is raised on the edge entering the final HOLD cycle
    last_hold  = (CLK_DIV == 1) ? shift_done : (state == HOLD && cnt == HM1 - 16'd1);
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      cnt       <= '0;
      ph        <= 1'b0;
      bits      <= '0;
      sh        <= '0;
      rsh       <= '0;
      wr        <= 1'b0;
      req_ready <= 1'b1;
      rsp_valid <= 1'b0;
      rsp_rdata <= '0;
      spi_clk   <= 1'b0;
      spi_ncs   <= 1'b1;
      spi_do    <= 1'b0;
    end else begin
      rsp_valid <= last_hold;
      if (last_hold) rsp_rdata <= wr ? 32'h0 : rsh;
      if (smp && bits >= 6'd16) rsh <= {rsh[30:0], di};
      cnt <= cnt + 16'd1;
      case (state)
        IDLE: begin
          cnt <= '0;
          if (req_valid) begin
            state     <= SETUP;
            req_ready <= 1'b0;
            spi_ncs   <= 1'b0;
            spi_do    <= req_wr;
            wr        <= req_wr;
            sh        <= {3'b000, req_addr, req_wr ? req_wdata : 32'h0};
            rsh       <= '0;
          end
        end
        SETUP: if (h_end) begin
          state <= SHIFT;
          cnt   <= '0;
          ph    <= 1'b0;
          bits  <= '0;
        end
        SHIFT: if (h_end) begin
          cnt     <= '0;
          ph      <= !ph;
          spi_clk <= !ph;
          if (ph) begin
            if (bits == 6'd47) state <= HOLD;
            else begin
              bits   <= bits + 6'd1;
              spi_do <= sh[46];
              sh     <= {sh[45:0], 1'b0};
            end
          end
        end
        HOLD: if (h_end) begin
          state   <= GAP;
          cnt     <= '0;
          spi_ncs <= 1'b1;
          spi_do  <= 1'b0;
        end
        GAP: if (cnt == GM1) begin
          state     <= IDLE;
          cnt       <= '0;
          req_ready <= 1'b1;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_spir_master.sv
// tb_spir_master: scoreboard bench for spir_master with an SPI slave model per instance.
module tb_spir_master;
`ifdef SPIR_MASTER_SYNC_EN
  localparam int H0 = 3;
  localparam int NI = 1;
  localparam int SD = 1;
`else
  localparam int H0 = 4;
  localparam int NI = 2;
  localparam int SD = 0;
`endif
  localparam int G = 4;
  typedef struct {
    int          lat;
    logic [31:0] rd;
    logic [47:0] mosi;
  } exp_t;
  logic clk = 1'b0;
  logic rst;
  logic [1:0] rv, wr_in, rr, rspv, sclk, ncs, sdo;
  logic [1:0][11:0] ad;
  logic [1:0][31:0] wd, sdata, rdat;
  int cyc = 0;
  int tests = 0;
  int fails = 0;
  int viol = 0;
  int rises[2];
  int acc_prev[2];
  int acc_last[2];
  int gap_meas[2];
  exp_t q[2][$];
  int aq[2][$];
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  function automatic void chk(string nm, logic [63:0] act, logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endfunction
  function automatic int hd(int i);
    return (i == 0) ? H0 : 1;
  endfunction
  for (genvar i = 0; i < NI; i++) begin : g
    localparam int H = (i == 0) ? H0 : 1;
    logic miso = 1'b1;
    logic pclk = 1'b0;
    logic pdo = 1'b0;
    logic pncs = 1'b1;
    logic prr = 1'b1;
    logic nb = 1'b1;
    int falls = 0;
    int cd = -1;
    int t_rise = 0;
    int a;
    exp_t e;
    logic [47:0] mosi = '0;
    spir_master #(.CLK_DIV(H), .CS_GAP(G)) u_dut (
      .clk(clk), .reset(rst),
      .req_valid(rv[i]), .req_ready(rr[i]), .req_wr(wr_in[i]),
      .req_addr(ad[i]), .req_wdata(wd[i]),
      .rsp_valid(rspv[i]), .rsp_rdata(rdat[i]),
      .spi_clk(sclk[i]), .spi_ncs(ncs[i]), .spi_do(sdo[i]), .spi_di(miso)
    );
    always @(negedge clk) begin
      if (!rst && rv[i] && rr[i]) begin
        aq[i].push_back(cyc);
        acc_prev[i] = acc_last[i];
        acc_last[i] = cyc;
      end
      if (rspv[i]) begin
        if (q[i].size() == 0) begin
          tests++;
          fails++;
          $display("FAIL unexpected_rsp[%0d]: got rsp_valid=1 expected none", i);
        end else begin
          e = q[i].pop_front();
          a = (aq[i].size() != 0) ? aq[i].pop_front() : -1;
          chk($sformatf("rdata[%0d]", i), 64'(rdat[i]), 64'(e.rd));
          chk($sformatf("latency[%0d]", i), 64'(cyc - a), 64'(e.lat));
          chk($sformatf("mosi[%0d]", i), 64'(mosi), 64'(e.mosi));
          chk($sformatf("rises[%0d]", i), 64'(rises[i]), 64'd48);
        end
      end
      if (ncs[i]) begin
        rises[i] = 0;
        falls = 0;
        cd = -1;
        miso = 1'b1;
      end else begin
        if (sclk[i] && !pclk) begin
          rises[i]++;
          mosi = {mosi[46:0], sdo[i]};
        end
        if (sclk[i] && pclk && sdo[i] !== pdo) viol++;
        if (!sclk[i] && pclk) begin
          falls++;
          nb = (falls >= 16 && falls <= 47) ? sdata[i][47 - falls] : 1'b1;
          cd = SD;
        end
        if (cd == 0) miso = nb;
        if (cd >= 0) cd--;
      end
      if (ncs[i] && !pncs) t_rise = cyc;
      if (rr[i] && !prr) gap_meas[i] = cyc - t_rise;
      pclk = sclk[i];
      pdo = sdo[i];
      pncs = ncs[i];
      prr = rr[i];
    end
  end
  task automatic step();
    @(posedge clk);
    #1;
  endtask
  task automatic send(int i, bit w, logic [11:0] a, logic [31:0] d, logic [31:0] sd, bit keep);
    exp_t e;
    int n;
    e.lat = 98 * hd(i);
    e.rd = w ? 32'h0 : sd;
    e.mosi = {w, 3'b000, a, w ? d : 32'h0};
    q[i].push_back(e);
    step();
    sdata[i] = sd;
    wr_in[i] = w;
    ad[i] = a;
    wd[i] = d;
    rv[i] = 1'b1;
    n = 0;
    while (!rr[i] && n < 5000) begin
      step();
      n++;
    end
    if (!rr[i]) begin
      tests++;
      fails++;
      $display("FAIL accept_timeout[%0d]: got req_ready=0 expected 1", i);
    end
    step();
    if (!keep) rv[i] = 1'b0;
  endtask
  task automatic wait_done(int i);
    int n;
    n = 0;
    while (q[i].size() != 0 && n < 20000) begin
      step();
      n++;
    end
    if (q[i].size() != 0) begin
      tests++;
      fails++;
      $display("FAIL rsp_timeout[%0d]: got %0d pending expected 0", i, q[i].size());
      q[i].delete();
      aq[i].delete();
    end
    repeat (G + 2) step();
  endtask
  initial begin
    #5_000_000;
    $display("FAIL watchdog: got no finish expected finish");
    $fatal(1, "watchdog");
  end
  initial begin
    int n;
    rst = 1'b1;
    rv = '0;
    wr_in = '0;
    ad = '0;
    wd = '0;
    sdata = '0;
    repeat (2) step();
    rv[0] = 1'b1;
    step();
    chk("rst_ready", 64'(rr[0]), 64'd1);
    chk("rst_rsp_valid", 64'(rspv[0]), 64'd0);
    chk("rst_rdata", 64'(rdat[0]), 64'd0);
    chk("rst_spi_clk", 64'(sclk[0]), 64'd0);
    chk("rst_spi_ncs", 64'(ncs[0]), 64'd1);
    chk("rst_spi_do", 64'(sdo[0]), 64'd0);
    rv[0] = 1'b0;
    rst = 1'b0;
    step();
    send(0, 1'b1, 12'hC01, 32'h000000C3, 32'hFFFFFFFF, 1'b0);
    wait_done(0);
    send(0, 1'b0, 12'hC00, 32'hFFFF0000, 32'h00800001, 1'b0);
    wait_done(0);
    send(0, 1'b0, 12'h3A5, 32'h0, 32'h12345678, 1'b0);
    wait_done(0);
    send(0, 1'b1, 12'h123, 32'hDEADBEEF, 32'hFFFFFFFF, 1'b1);
    send(0, 1'b1, 12'h7FF, 32'h0F0F0F0F, 32'hFFFFFFFF, 1'b0);
    wait_done(0);
    chk("b2b_accept_gap", 64'(acc_last[0] - acc_prev[0]), 64'(98 * H0 + 1 + G));
    chk("b2b_ncs_gap", 64'(gap_meas[0]), 64'(G));
    send(0, 1'b0, 12'h456, 32'h0, 32'h11111111, 1'b0);
    n = 0;
    while (rises[0] != 20 && n < 5000) begin
      step();
      n++;
    end
    chk("abort_at_bit20", 64'(rises[0]), 64'd20);
    rst = 1'b1;
    q[0].delete();
    aq[0].delete();
    step();
    chk("abort_ncs", 64'(ncs[0]), 64'd1);
    chk("abort_spi_clk", 64'(sclk[0]), 64'd0);
    chk("abort_ready", 64'(rr[0]), 64'd1);
    chk("abort_rsp_valid", 64'(rspv[0]), 64'd0);
    rst = 1'b0;
    repeat (100 * H0) step();
    send(0, 1'b0, 12'h456, 32'h0, 32'h89ABCDEF, 1'b0);
    wait_done(0);
`ifndef SPIR_MASTER_SYNC_EN
    send(1, 1'b0, 12'h00F, 32'h0, 32'hA5A5F00F, 1'b0);
    wait_done(1);
    send(1, 1'b1, 12'h801, 32'h5A5A0FF0, 32'hFFFFFFFF, 1'b0);
    wait_done(1);
`endif
    chk("do_change_in_high_phase", 64'(viol), 64'd0);
    chk("pending_rsp", 64'(q[0].size()), 64'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/spir_master.md
# spir_master

SPI initiator that issues single 32-bit register reads and writes to the board's SPI register slave (`spir`), i.e. the MCU-side end of the `spi_clk`/`spi_ncs`/`spi_din`/`spi_dout` link. It is used in FPGA self-test builds, where a second device or a loopback harness drives the ArcDVI register map from logic, and as the bus-functional master in simulation. A simple valid/ready request port on the `clk` domain is serialised into one SPI frame per transaction, and read data is returned on a one-cycle response strobe.

## Interface
- `CLK_DIV`, 4: SPI half-period in `clk` cycles (H); legal range 1..255 (3..255 with sync option).
- `CS_GAP`, 4: minimum `clk` cycles `spi_ncs` stays high between frames; legal range ≥1.
- `clk` in 1: system clock; all logic is on its rising edge.
- `reset` in 1: synchronous, active-high reset.
- `req_valid` in 1: request present.
- `req_ready` out 1: request accepted when both `req_valid` and `req_ready` are high.
- `req_wr` in 1: 1 = write, 0 = read.
- `req_addr` in 12: register word address, the same field `spir` presents as `r_addr`.
- `req_wdata` in 32: write data; ignored for reads.
- `rsp_valid` out 1: one-cycle pulse when the frame completes.
- `rsp_rdata` out 32: captured read data, valid with `rsp_valid`; 0 for writes.
- `spi_clk` out 1: SPI clock, idle low (mode 0).
- `spi_ncs` out 1: chip select, active low.
- `spi_do` out 1: MOSI; connects to the slave's data-in.
- `spi_di` in 1: MISO; connects to the slave's data-out.

## Operation
- Frame format, MSB first, 48 bits: 16-bit header `{req_wr, 3'b000, req_addr[11:0]}` followed by 32 data bits.
  - Write: the master drives `req_wdata[31:0]` on `spi_do`.
  - Read: the master drives 0 on `spi_do`, and the slave drives data on `spi_di`.
- Request fields are latched on acceptance. Later changes to the inputs have no effect on the frame in flight.
- States:
  - IDLE: `req_ready`=1. On accept, go to SETUP.
  - SETUP: `spi_ncs`=0, `spi_clk`=0, `spi_do`=bit 47. Lasts H cycles, then SHIFT.
  - SHIFT: each bit is a low phase of H cycles followed by a high phase of H cycles.
    - `spi_do` changes only at the start of a low phase.
    - After 48 bits, go to HOLD.
  - HOLD: `spi_clk`=0, `spi_ncs`=0 for H cycles. On the last HOLD cycle, assert `rsp_valid` and go to GAP.
  - GAP: `spi_ncs`=1 for `CS_GAP` cycles, then IDLE.
- Read data sampling: only the last 32 bits are shifted into `rsp_rdata`; header-phase `spi_di` values are discarded. The sample point is defined under Configuration.
- All outputs are registered.

## Timing
- Reset values: `req_ready`=1, `rsp_valid`=0, `rsp_rdata`=0, `spi_clk`=0, `spi_ncs`=1, `spi_do`=0.
- Acceptance happens on edge E. `spi_ncs` falls at E+1.
- The first `spi_clk` rise is at E+1+2H.
- `rsp_valid` is high during cycle E+98H (with H=4, the pulse is at cycle E+392).
- `spi_ncs` rises at E+98H+1. `req_ready` returns at E+98H+1+`CS_GAP`.
- Next `spi_ncs` fall for back-to-back requests: E+98H+2+`CS_GAP`.
- `req_ready` is low from E+1 until the return to IDLE. Requests are never queued.
- `rsp_rdata` holds its value until the next `rsp_valid`.
- Reset mid-frame: the next cycle forces the reset values. No `rsp_valid` is produced for the aborted frame. The slave sees `spi_ncs` rise and discards the partial frame.
- `req_valid` asserted during reset is ignored. Acceptance is possible from the first cycle after reset deasserts.

## Configuration
- `SPIR_MASTER_SYNC_EN` defined:
  - `spi_di` passes through a 2-flop synchroniser.
  - Each bit is sampled on the last cycle of its high phase.
  - Requires `CLK_DIV` ≥ 3; a simulation `$error` fires otherwise.
- `SPIR_MASTER_SYNC_EN` undefined:
  - `spi_di` is sampled unsynchronised on the `clk` edge at which `spi_clk` is driven high.
  - This is for simulation, or for slaves on the same clock domain.
- Frame timing and all other latencies are identical in both builds.

## Test plan
- Write: `req_wr`=1, addr 0xC01, wdata 0x000000C3, H=4.
  - MOSI stream is 0x8C01 then 0x000000C3, with 48 rising edges.
  - `rsp_valid` fires at E+392 with `rsp_rdata`=0.
- Read: addr 0xC00, slave model returns 0x00800001.
  - MOSI header is 0x0C00 and data bits are all 0.
  - `rsp_rdata`=0x00800001.
- Back-to-back: `req_valid` is held high for two writes.
  - `spi_ncs` is high for exactly `CS_GAP` cycles between frames.
  - Second acceptance occurs at E+98H+1+`CS_GAP`.
- Reset at bit 20 of a read:
  - `spi_ncs`=1, `spi_clk`=0, `req_ready`=1 on the next cycle.
  - No `rsp_valid`.
  - A following read returns correct data.
- `CLK_DIV`=1 without the sync option: a read of 0xA5A5F00F completes with `rsp_valid` at E+98 and correct data.
- With `SPIR_MASTER_SYNC_EN` defined and `CLK_DIV`=3, the slave changes MISO 1 cycle after each falling edge.
  - Read data 0x12345678 is captured correctly.
